// File: rtl/taylor_cos_seq.sv
// Sequential Horner-form cosine: x^(2*TERMS) Maclaurin series on one
// shared single-precision multiplier (nhan) and one shared adder (cong_tru).

module nhan (
  input  logic [31:0] ma,
  input  logic [31:0] mb,
  output logic [31:0] p
);
  logic               s;
  logic [7:0]         ea;
  logic [7:0]         eb;
  logic               a_z, b_z;
  logic               a_inf, b_inf;
  logic               a_nan, b_nan;
  logic [47:0]        prod;
  logic [22:0]        frac;
  logic               g, st;
  logic signed [10:0] e;
  logic [30:0]        pk;

  assign ea    = ma[30:23];
  assign eb    = mb[30:23];
  assign a_z   = (ea == 8'd0);
  assign b_z   = (eb == 8'd0);
  assign a_inf = (ea == 8'hFF) && (ma[22:0] == 23'd0);
  assign b_inf = (eb == 8'hFF) && (mb[22:0] == 23'd0);
  assign a_nan = (ea == 8'hFF) && (ma[22:0] != 23'd0);
  assign b_nan = (eb == 8'hFF) && (mb[22:0] != 23'd0);

  always_comb begin
    s    = ma[31] ^ mb[31];
    prod = {24'd0, 1'b1, ma[22:0]} * {24'd0, 1'b1, mb[22:0]};
    e    = $signed({3'd0, ea}) + $signed({3'd0, eb}) - 11'sd127;
    if (prod[47]) begin
      frac = prod[46:24];
      g    = prod[23];
      st   = |prod[22:0];
      e    = e + 11'sd1;
    end else begin
      frac = prod[45:23];
      g    = prod[22];
      st   = |prod[21:0];
    end
    // rounding carry ripples straight into the exponent field
    pk = {e[7:0], frac} + {30'd0, g & (st | frac[0])};
    if (a_nan || b_nan || (a_inf && b_z) || (b_inf && a_z))
      p = 32'h7FC00000;
    else if (a_inf || b_inf)
      p = {s, 8'hFF, 23'd0};
    else if (a_z || b_z)
      p = {s, 31'd0};
    else if (e >= 11'sd255)
      p = {s, 8'hFF, 23'd0};
    else if (e <= 11'sd0)
      p = {s, 31'd0};
    else
      p = {s, pk};
  end
endmodule

module cong_tru (
  input  logic [31:0] aa,
  input  logic [31:0] ab,
  input  logic        operation,
  output logic [31:0] sum
);
  logic [31:0]       b;
  logic [31:0]       big;
  logic [31:0]       sml;
  logic [7:0]        d8;
  logic [5:0]        d;
  logic [49:0]       fb;
  logic [49:0]       fs;
  logic [49:0]       sh;
  logic [50:0]       s;
  logic [49:0]       n;
  logic [5:0]        lz;
  logic signed [9:0] e;
  logic [30:0]       pk;
  logic              big_ff, sml_ff;

  always_comb begin
    b = {ab[31] ^ operation, ab[30:0]};
    if (aa[30:0] >= b[30:0]) begin
      big = aa;
      sml = b;
    end else begin
      big = b;
      sml = aa;
    end
    big_ff = (big[30:23] == 8'hFF);
    sml_ff = (sml[30:23] == 8'hFF);
    d8 = big[30:23] - sml[30:23];
    d  = (d8 > 8'd63) ? 6'd63 : d8[5:0];
    fb = {1'b1, big[22:0], 26'd0};
    fs = {1'b1, sml[22:0], 26'd0};
    sh = fs >> d;
    // bits shifted past the guard field collapse into a sticky LSB
    sh[0] = sh[0] | (|(fs & ((50'd1 << d) - 50'd1)));
    if (big[31] == sml[31])
      s = {1'b0, fb} + {1'b0, sh};
    else
      s = {1'b0, fb} - {1'b0, sh};
    lz = 6'd0;
    for (int i = 0; i < 51; i++)
      if (s[i]) lz = 6'(50 - i);
    n  = s[49:0] << lz;
    e  = $signed({2'd0, big[30:23]}) + 10'sd1
       - $signed({4'd0, lz});
    pk = {e[7:0], n[49:27]}
       + {30'd0, n[26] & ((|n[25:0]) | n[27])};
    if (big_ff || sml_ff) begin
      if ((big_ff && big[22:0] != 23'd0) ||
          (sml_ff && big[31] != sml[31]))
        sum = 32'h7FC00000;
      else
        sum = big;
    end else if (sml[30:23] == 8'd0) begin
      if (big[30:23] == 8'd0)
        sum = {big[31] & sml[31], 31'd0};
      else
        sum = big;
    end else if (s == 51'd0)
      sum = 32'd0;
    else if (e >= 10'sd255)
      sum = {big[31], 8'hFF, 23'd0};
    else if (e <= 10'sd0)
      sum = {big[31], 31'd0};
    else
      sum = {big[31], pk};
  end
endmodule

module taylor_cos_seq #(
  parameter int TERMS = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] in,
  output logic [31:0] out,
  output logic        busy,
  output logic        done
);
  typedef enum logic [1:0] {IDLE, SQR, MUL, ADD} state_t;

  localparam logic [2:0] NT = 3'(TERMS);

  state_t      state, state_n;
  logic [31:0] x, x_n;
  logic [31:0] x2, x2_n;
  logic [31:0] acc, acc_n;
  logic [2:0]  cnt, cnt_n;
  logic [31:0] out_n;
  logic        busy_n, done_n;
  logic [31:0] mul_a, mul_b, prod;
  logic [31:0] add_b, sum;

  // c_2k = (-1)^k / (2k)!
  function automatic logic [31:0] coef(input logic [2:0] k);
    case (k)
      3'd6:    coef = 32'h310F76C7;
      3'd5:    coef = 32'hB493F27E;
      3'd4:    coef = 32'h37D00D01;
      3'd3:    coef = 32'hBAB60B61;
      3'd2:    coef = 32'h3D2AAAAB;
      3'd1:    coef = 32'hBF000000;
      default: coef = 32'h3F800000;
    endcase
  endfunction

  assign mul_a = (state == SQR) ? x : acc;
  assign mul_b = (state == SQR) ? x : x2;
  assign add_b = coef(cnt - 3'd1);

  nhan u_mul (
    .ma (mul_a),
    .mb (mul_b),
    .p  (prod)
  );

  cong_tru u_add (
    .aa        (acc),
    .ab        (add_b),
    .operation (1'b0),
    .sum       (sum)
  );

  always_comb begin
    state_n = state;
    x_n     = x;
    x2_n    = x2;
    acc_n   = acc;
    cnt_n   = cnt;
    out_n   = out;
    busy_n  = busy;
    done_n  = 1'b0;
    unique case (state)
      IDLE: if (start) begin
        x_n     = in;
        acc_n   = coef(NT);
        cnt_n   = NT;
        busy_n  = 1'b1;
        state_n = SQR;
      end
      SQR: begin
        x2_n    = prod;
        state_n = MUL;
      end
      MUL: begin
        acc_n   = prod;
        state_n = ADD;
      end
      ADD: begin
        acc_n = sum;
        cnt_n = cnt - 3'd1;
        if (cnt == 3'd1) begin
          out_n   = sum;
          done_n  = 1'b1;
          busy_n  = 1'b0;
          state_n = IDLE;
        end else begin
          state_n = MUL;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      x     <= '0;
      x2    <= '0;
      acc   <= '0;
      cnt   <= '0;
      out   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_n;
      x     <= x_n;
      x2    <= x2_n;
      acc   <= acc_n;
      cnt   <= cnt_n;
      out   <= out_n;
      busy  <= busy_n;
      done  <= done_n;
    end
  end
endmodule

// File: tb/tb_taylor_cos_seq.sv
// Bench for taylor_cos_seq: fixed vectors, handshake/reset sequences and
// random operands against a double-precision series model.

module tb_taylor_cos_seq;
  logic        clk = 1'b0;
  logic        rst;
  logic        start6, start1, start3;
  logic [31:0] in6, in1, in3;
  logic [31:0] out6, out1, out3;
  logic        busy6, busy1, busy3;
  logic        done6, done1, done3;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  taylor_cos_seq #(.TERMS(6)) dut6 (
    .clk(clk), .rst(rst), .start(start6), .in(in6),
    .out(out6), .busy(busy6), .done(done6));
  taylor_cos_seq #(.TERMS(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .in(in1),
    .out(out1), .busy(busy1), .done(done1));
  taylor_cos_seq #(.TERMS(3)) dut3 (
    .clk(clk), .rst(rst), .start(start3), .in(in3),
    .out(out3), .busy(busy3), .done(done3));

  typedef struct {
    int          sel;
    logic [31:0] x;
    logic [31:0] expv;
    int          tol;
    int          lat;
  } vec_t;

  vec_t vec [7];

  function automatic real f2r(input logic [31:0] f);
    logic [10:0] e;
    if (f[30:23] == 8'd0) return 0.0;
    e = {3'd0, f[30:23]} + 11'd896;
    return $bitstoreal({f[31], e, f[22:0], 29'd0});
  endfunction

  function automatic logic [31:0] r2f(input real r);
    logic [63:0] d;
    logic [30:0] pk;
    int          e;
    d = $realtobits(r);
    if (r == 0.0) return {d[63], 31'd0};
    e  = int'(d[62:52]) - 896;
    pk = {e[7:0], d[51:29]};
    pk = pk + {30'd0, d[28] & ((|d[27:0]) | d[29])};
    return {d[63], pk};
  endfunction

  function automatic longint ulp(input logic [31:0] a,
                                 input logic [31:0] b);
    longint oa, ob, df;
    oa = a[31] ? -longint'(a[30:0]) : longint'(a[30:0]);
    ob = b[31] ? -longint'(b[30:0]) : longint'(b[30:0]);
    df = oa - ob;
    return (df < 0) ? -df : df;
  endfunction

  // sum_{k=0..terms} (-1)^k x^2k / (2k)!
  function automatic real model(input real x, input int terms);
    real s, t;
    s = 0.0;
    t = 1.0;
    for (int k = 0; k <= terms; k++) begin
      s = s + t;
      t = -t * x * x / real'((2 * k + 1) * (2 * k + 2));
    end
    return s;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] expv, input int tol);
    checks++;
    if ($isunknown(act) || ulp(act, expv) > longint'(tol)) begin
      errors++;
      $display("FAIL %s: got %h want %h (tol %0d)",
               nm, act, expv, tol);
    end
  endtask

  task automatic drive(input int sel, input logic s,
                       input logic [31:0] v);
    case (sel)
      1:       begin start1 = s; in1 = v; end
      3:       begin start3 = s; in3 = v; end
      default: begin start6 = s; in6 = v; end
    endcase
  endtask

  function automatic logic [33:0] peek(input int sel);
    case (sel)
      1:       return {busy1, done1, out1};
      3:       return {busy3, done3, out3};
      default: return {busy6, done6, out6};
    endcase
  endfunction

  // called #1 after a rising edge; the next edge accepts the start
  task automatic op(input int sel, input logic [31:0] v,
                    output logic [31:0] r, output int lat,
                    output int bcnt);
    logic [33:0] p;
    drive(sel, 1'b1, v);
    @(posedge clk); #1;
    drive(sel, 1'b0, v);
    lat  = 0;
    bcnt = 0;
    r    = '0;
    p    = peek(sel);
    if (p[33]) bcnt++;
    forever begin
      @(posedge clk); #1;
      lat++;
      p = peek(sel);
      if (p[32]) begin
        r = p[31:0];
        if (p[33]) bcnt = 99;
        break;
      end
      if (p[33]) bcnt++;
      if (lat >= 40) begin
        checks++;
        errors++;
        $display("FAIL timeout: sel %0d no done after %0d cycles",
                 sel, lat);
        break;
      end
    end
  endtask

  logic [31:0] r, r_one, r_half, r_neg, r2;
  logic [31:0] r_first, r_second, xb;
  int          lat, bc, dcount, t_first, t_second;
  bit          dseen;
  real         xr, rv, err;

  initial begin
    vec[0] = '{6, 32'h00000000, 32'h3F800000, 0, 13};
    vec[1] = '{6, 32'h80000000, 32'h3F800000, 0, 13};
    vec[2] = '{6, 32'h3F800000, 32'h3F0A5140, 2, 13};
    vec[3] = '{6, 32'h3F000000, 32'h3F60A940, 2, 13};
    vec[4] = '{1, 32'h3F800000, 32'h3F000000, 0, 3};
    vec[5] = '{3, 32'h3F800000, 32'h3F0A4FA5, 1, 7};
    vec[6] = '{1, 32'h00000000, 32'h3F800000, 0, 3};

    rst = 1'b1;
    start6 = 0; start1 = 0; start3 = 0;
    in6 = '0; in1 = '0; in3 = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out", out6, 32'h0, 0);
    chk("rst_busy", 32'(busy6), 32'h0, 0);
    chk("rst_done", 32'(done6), 32'h0, 0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;

    r_one  = '0;
    r_half = '0;
    for (int i = 0; i < 7; i++) begin
      op(vec[i].sel, vec[i].x, r, lat, bc);
      chk($sformatf("vec%0d_out", i), r, vec[i].expv, vec[i].tol);
      chk($sformatf("vec%0d_lat", i), 32'(lat), 32'(vec[i].lat), 0);
      chk($sformatf("vec%0d_busy", i), 32'(bc), 32'(vec[i].lat), 0);
      if (i == 2) r_one = r;
      if (i == 3) r_half = r;
    end

    op(6, 32'hBF800000, r_neg, lat, bc);
    chk("neg_one_sym", r_neg, r_one, 0);

    op(6, 32'h3FC90FDB, r, lat, bc);
    err = f2r(r);
    checks++;
    if ($isunknown(r) || err > 1e-5 || err < -1e-5) begin
      errors++;
      $display("FAIL half_pi: got %h want |out| < 1e-5", r);
    end

    // start pulses while busy are ignored; start in done cycle is taken
    drive(6, 1'b1, 32'h3F800000);
    @(posedge clk); #1;
    drive(6, 1'b0, 32'h3F800000);
    dcount = 0; t_first = -1; t_second = -1;
    r_first = '0; r_second = '0;
    for (int e = 1; e <= 30; e++) begin
      @(posedge clk); #1;
      if (done6) begin
        dcount++;
        if (t_first < 0) begin
          t_first = e; r_first = out6;
        end else begin
          t_second = e; r_second = out6;
        end
      end
      start6 = 1'b0;
      if (e == 2)  begin start6 = 1'b1; in6 = 32'h3F000000; end
      if (e == 11) begin start6 = 1'b1; in6 = 32'h40000000; end
      if (e == 13 && done6) begin
        start6 = 1'b1; in6 = 32'h3F000000;
      end
    end
    start6 = 1'b0;
    chk("hs_first_t", 32'(t_first), 32'd13, 0);
    chk("hs_first_val", r_first, r_one, 0);
    chk("hs_done_cnt", 32'(dcount), 32'd2, 0);
    chk("hs_spacing", 32'(t_second - t_first), 32'd14, 0);
    chk("hs_second_val", r_second, r_half, 0);

    // abort mid-operation
    drive(6, 1'b1, 32'h3F800000);
    @(posedge clk); #1;
    drive(6, 1'b0, 32'h3F800000);
    repeat (5) begin @(posedge clk); #1; end
    rst = 1'b1;
    #1;
    chk("abort_out", out6, 32'h0, 0);
    chk("abort_busy", 32'(busy6), 32'h0, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    dseen = 1'b0;
    repeat (20) begin
      @(posedge clk); #1;
      if (done6) dseen = 1'b1;
    end
    chk("abort_no_done", 32'(dseen), 32'h0, 0);
    op(6, 32'h3F000000, r, lat, bc);
    chk("after_abort", r, 32'h3F60A940, 2);
    chk("after_abort_lat", 32'(lat), 32'd13, 0);

    for (int i = 0; i < 1000; i++) begin
      xr = real'($urandom_range(0, 1000000)) / 1000000.0 * 1.5707963;
      xb = r2f(xr);
      if ($urandom_range(0, 1) == 1) xb[31] = 1'b1;
      op(6, xb, r, lat, bc);
      rv  = model(f2r(xb), 6);
      err = f2r(r) - rv;
      checks++;
      if ($isunknown({r, done6, busy6}) || lat != 13 ||
          err > 3e-7 || err < -3e-7) begin
        errors++;
        $display("FAIL rand%0d: x %h got %h want %h lat %0d",
                 i, xb, r, r2f(rv), lat);
      end
      if (i < 100) begin
        op(6, {~xb[31], xb[30:0]}, r2, lat, bc);
        chk($sformatf("sym%0d", i), r2, r, 0);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
